// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the iterative MUL/DIV/REM unit.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [TAG_WIDTH-1:0] out_tag;

    // Requester side (pipeline).
    modport master (
        output in_valid, in_op, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Execution unit side.
    modport slave (
        input  in_valid, in_op, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider with a one-op-at-a-time handshake.
module muldiv_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    muldiv_sequencer_if.slave    bus,
    output logic                 busy
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [1:0] OpMul  = 2'd0;
    localparam logic [1:0] OpMulh = 2'd1;
    localparam logic [1:0] OpDiv  = 2'd2;
    localparam logic [1:0] OpRem  = 2'd3;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFixup, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 signed_q, signed_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {high partial, multiplier/low product}. Divide: low half holds the quotient.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic                 a_neg, b_neg, div_zero, div_ovf, div_ge;
    logic [WIDTH-1:0]     a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]       mul_sum, div_shift, div_sub;
    logic [2*WIDTH-1:0]   prod_fix;

    // Next-state and datapath for every state of the sequencer.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        signed_d  = signed_q;
        neg_d     = neg_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;

        a_neg    = signed_q & a_q[WIDTH-1];
        b_neg    = signed_q & b_q[WIDTH-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        div_zero = (b_q == '0);
        div_ovf  = signed_q && (a_q == MinNeg) && (b_q == '1);

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = (rem_q << 1) | (WIDTH + 1)'(acc_q[WIDTH-1]);
        div_ge    = (div_shift >= {1'b0, b_q});
        div_sub   = div_shift - {1'b0, b_q};

        // The sign is applied to the full product so MULH sees the borrow from the low half.
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d     = bus.in_op;
                    signed_d = bus.in_signed;
                    a_d      = bus.in_a;
                    b_d      = bus.in_b;
                    tag_d    = bus.in_tag;
                    state_d  = StPrep;
                end
            end
            StPrep: begin
                neg_d = (op_q == OpRem) ? a_neg : (a_neg ^ b_neg);
                a_d   = a_mag;
                b_d   = b_mag;
                if (op_q[1] && div_zero) begin
                    result_d  = (op_q == OpDiv) ? '1 : a_q;
                    out_tag_d = tag_q;
                    state_d   = StDone;
                end else if (op_q[1] && div_ovf) begin
                    result_d  = (op_q == OpDiv) ? a_q : '0;
                    out_tag_d = tag_q;
                    state_d   = StDone;
                end else begin
                    cnt_d   = CntW'(WIDTH);
                    rem_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, (op_q[1] ? a_mag : b_mag)};
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (op_q[1]) begin
                    rem_d              = div_ge ? div_sub : div_shift;
                    acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                unique case (op_q)
                    OpMul:   result_d = prod_fix[WIDTH-1:0];
                    OpMulh:  result_d = prod_fix[2*WIDTH-1:WIDTH];
                    OpDiv:   result_d = quo_fix;
                    OpRem:   result_d = rem_fix;
                    default: result_d = result_q;
                endcase
                out_tag_d = tag_q;
                state_d   = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort beats everything except reset, including a same-edge accept.
        if (flush) begin
            state_d = StIdle;
        end
    end

    // All state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            signed_q  <= 1'b0;
            neg_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            signed_q  <= signed_d;
            neg_q     <= neg_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = result_q;
    assign bus.out_tag    = out_tag_q;
    assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on handoff.
module tb_muldiv_sequencer;
    localparam int unsigned W      = 32;
    localparam int unsigned TW     = 5;
    localparam int          LatN   = W + 2;
    localparam int          Bound  = 100;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic reset, flush, busy;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   busy_drop = 0;
    exp_t sb_q[$];

    muldiv_sequencer_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

    muldiv_sequencer #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: compare each handed-off result against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, 64'(bus.out_result), 64'(e.res));
                    check({e.name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
                end
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic [W-1:0] exp,
                         input bit push);
        int waitc;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_signed = sgn;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        waitc = 0;
        while (!bus.in_ready && waitc < Bound) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (waitc >= Bound) check({name, "_accept_timeout"}, 64'(waitc), 64'd0);
        if (push) sb_q.push_back('{res: exp, tag: tag, name: name});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!busy) busy_drop++;
        end while (!bus.out_valid && lat < Bound);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input logic [W-1:0] exp,
                          input int lat_exp);
        int lat;
        issue(name, op, sgn, a, b, tag, exp, 1'b1);
        check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(lat_exp));
        @(posedge clk); #1;
        check({name, "_idle_after_handoff"}, 64'({busy, bus.in_ready, bus.out_valid}),
              64'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_signed = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_result", 64'(bus.out_result), 64'd0);
        check("reset_out_tag", 64'(bus.out_tag), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Multiply and divide vectors; special cases complete one edge after accept.
        run_op("mul_s_7x-3",    2'd0, 1'b1, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LatN);
        run_op("mulh_s_min2",   2'd1, 1'b1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, LatN);
        run_op("mulh_u_max2",   2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, LatN);
        run_op("mul_u_max2",    2'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000001, LatN);
        run_op("mul_u_x9",      2'd0, 1'b0, 32'h12345678, 32'd9,        5'd9,  32'hA3D70A38, LatN);
        run_op("div_s_-7/2",    2'd2, 1'b1, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, LatN);
        run_op("rem_s_-7/2",    2'd3, 1'b1, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, LatN);
        run_op("div_u_100/7",   2'd2, 1'b0, 32'd100,      32'd7,        5'd12, 32'd14,       LatN);
        run_op("rem_u_100/7",   2'd3, 1'b0, 32'd100,      32'd7,        5'd13, 32'd2,        LatN);
        run_op("div_u_5/0",     2'd2, 1'b0, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        run_op("rem_u_5/0",     2'd3, 1'b0, 32'd5,        32'd0,        5'd15, 32'd5,        1);
        run_op("div_s_ovf",     2'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        run_op("rem_s_ovf",     2'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);
        check("busy_held_until_valid", 64'(busy_drop), 64'd0);

        // Backpressure: result must hold and a competing request must be refused.
        bus.out_ready = 1'b0;
        issue("bp_div", 2'd2, 1'b0, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(LatN));
        issue_hold: begin
            bus.in_valid  = 1'b1;
            bus.in_op     = 2'd0;
            bus.in_signed = 1'b0;
            bus.in_a      = 32'd2;
            bus.in_b      = 32'd2;
            bus.in_tag    = 5'd1;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_%0d", i),
                  64'({bus.out_valid, bus.in_ready, bus.out_tag, bus.out_result}),
                  64'({1'b1, 1'b0, 5'd9, 32'd14}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'({bus.out_valid, bus.in_ready, busy}), 64'(3'b010));
        @(posedge clk); #1;
        check("bp_no_late_accept", 64'(busy), 64'd0);

        // Flush on the 10th CALC cycle discards the operation.
        issue("flush_div", 2'd2, 1'b0, 32'd1000, 32'd3, 5'd3, 32'd333, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_state", 64'({busy, bus.in_ready, bus.out_valid}), 64'(3'b010));
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid || busy) seen++;
        end
        check("flush_no_output", 64'(seen), 64'd0);
        run_op("div_u_9/3", 2'd2, 1'b0, 32'd9, 32'd3, 5'd4, 32'd3, LatN);

        // Reset mid-CALC returns every output to its reset value.
        issue("reset_mul", 2'd0, 1'b0, 32'd3, 32'd3, 5'd7, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_outputs",
              64'({busy, bus.in_ready, bus.out_valid, bus.out_tag, bus.out_result}),
              64'({1'b0, 1'b1, 1'b0, 5'd0, 32'd0}));
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
